pc_sequencer: RTL and testbench

- Program-counter sequencing stage directly downstream of the branch-condition mux.
- Consumes the resolved branch condition (MP), an unconditional jump request, and a signed branch offset.
- Produces the next instruction address, a pipeline-flush pulse, and a valid qualifier that masks the wrong-path slots after a redirect.
- Keeps a saturating count of taken redirects for debug.

---
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks next PC from sequential / relative branch /
// absolute jump, pulses flush and masks pc_valid for the wrong-path slots.
module pc_sequencer #(
  parameter int PC_W = 16,
  parameter int OFF_W = 8,
  parameter int FLUSH_CYCLES = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             inst_valid,
  input  logic             MP,
  input  logic             JMP,
  input  logic [OFF_W-1:0] offset,
  input  logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             flush,
  output logic [7:0]       taken_cnt,
  output logic             fsm_state
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t            state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic [PC_W-1:0]   pc_n;
  logic              pc_valid_n;
  logic              flush_n;
  logic [7:0]        taken_cnt_n;
  logic [PC_W-1:0]   off_ext;
  logic              taken;

  assign off_ext   = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign fsm_state = (state == FLUSH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= 2'd0;
      pc        <= RESET_PC;
      pc_valid  <= 1'b1;
      flush     <= 1'b0;
      taken_cnt <= 8'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pc        <= pc_n;
      pc_valid  <= pc_valid_n;
      flush     <= flush_n;
      taken_cnt <= taken_cnt_n;
    end
  end

  // MP/JMP/offset/target are only sampled when inst_valid=1 and stall=0 in RUN;
  // the nested ifs keep unknown MP/JMP values out of the next-state logic otherwise.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pc_n        = pc;
    pc_valid_n  = pc_valid;
    flush_n     = 1'b0;
    taken_cnt_n = taken_cnt;
    taken       = 1'b0;
    case (state)
      RUN: begin
        if (!stall) begin
          pc_n = pc + PC_W'(1);
          if (inst_valid) begin
            if (JMP) begin
              pc_n  = target;
              taken = 1'b1;
            end else if (MP) begin
              pc_n  = pc + PC_W'(1) + off_ext;
              taken = 1'b1;
            end
          end
          if (taken) begin
            state_n     = FLUSH;
            flush_n     = 1'b1;
            pc_valid_n  = 1'b0;
            cnt_n       = CNT_INIT;
            taken_cnt_n = (taken_cnt == 8'hFF) ? taken_cnt : taken_cnt + 8'd1;
          end
        end
      end
      FLUSH: begin
        if (cnt == 2'd0) begin
          state_n    = RUN;
          pc_valid_n = 1'b1;
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (FLUSH_CYCLES=3): sequential flow, branch,
// jump priority, wrap-around, stall, counter saturation and async reset.
module tb_pc_sequencer;

  localparam int FC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        inst_valid;
  logic        MP;
  logic        JMP;
  logic [7:0]  offset;
  logic [15:0] target;
  logic [15:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [7:0]  taken_cnt;
  logic        fsm_state;

  int total = 0;
  int bad = 0;
  int exp_taken = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pc;

  pc_sequencer #(.PC_W(16), .OFF_W(8), .FLUSH_CYCLES(FC), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .inst_valid(inst_valid),
    .MP(MP), .JMP(JMP), .offset(offset), .target(target),
    .pc(pc), .pc_valid(pc_valid), .flush(flush), .taken_cnt(taken_cnt),
    .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0;
    inst_valid = 1'b0;
    MP = 1'bx;
    JMP = 1'bx;
  endtask

  // Applies the taken edge already set up by the caller, then walks the flush window
  // while driving noise that must be ignored.
  task automatic do_taken(input string tag, input logic [15:0] exp_pc_t);
    step();
    exp_taken = (exp_taken == 255) ? 255 : exp_taken + 1;
    chk({tag, "_flush"}, flush, 1);
    chk({tag, "_valid0"}, pc_valid, 0);
    chk({tag, "_pc"}, pc, exp_pc_t);
    chk({tag, "_state"}, fsm_state, 1);
    chk({tag, "_cnt"}, taken_cnt, exp_taken);
    stall = 1'b1; inst_valid = 1'b1; MP = 1'b1; JMP = 1'b1;
    target = 16'hDEAD; offset = 8'h40;
    for (int i = 1; i < FC; i++) begin
      step();
      chk({tag, "_flush_lo"}, flush, 0);
      chk({tag, "_valid_lo"}, pc_valid, 0);
      chk({tag, "_pc_hold"}, pc, exp_pc_t);
    end
    step();
    chk({tag, "_valid1"}, pc_valid, 1);
    chk({tag, "_flush_end"}, flush, 0);
    chk({tag, "_pc_end"}, pc, exp_pc_t);
    chk({tag, "_run"}, fsm_state, 0);
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    offset = 8'h00;
    target = 16'h0000;
    step();
    step();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_valid", pc_valid, 1);
    chk("rst_flush", flush, 0);
    chk("rst_cnt", taken_cnt, 0);
    chk("rst_state", fsm_state, 0);
    reset = 1'b0;

    // sequential flow with unknown MP/JMP while inst_valid=0
    for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
    while (exp_q.size() > 0) begin
      step();
      exp_pc = exp_q.pop_front();
      chk("seq_pc", pc, exp_pc);
      chk("seq_valid", pc_valid, 1);
      chk("seq_flush", flush, 0);
      chk("seq_cnt", taken_cnt, 0);
    end

    // jump to 0x0010, then relative branch +5 -> 0x0016
    inst_valid = 1'b1; JMP = 1'b1; MP = 1'b0; target = 16'h0010;
    do_taken("jmp10", 16'h0010);
    inst_valid = 1'b1; JMP = 1'b0; MP = 1'b1; offset = 8'h05;
    do_taken("br5", 16'h0016);

    // walk to 0x0020, then JMP beats MP
    for (int i = 0; i < 10; i++) step();
    chk("walk_pc", pc, 16'h0020);
    inst_valid = 1'b1; JMP = 1'b1; MP = 1'b1; target = 16'h1234; offset = 8'h7F;
    do_taken("jmp_prio", 16'h1234);

    // negative offset wraps below zero, sequential wraps above 0xFFFF
    inst_valid = 1'b1; JMP = 1'b1; MP = 1'b0; target = 16'h0002;
    do_taken("jmp2", 16'h0002);
    inst_valid = 1'b1; JMP = 1'b0; MP = 1'b1; offset = 8'hF8;
    do_taken("br_neg", 16'hFFFB);
    for (int i = 0; i < 4; i++) step();
    chk("wrap_ffff", pc, 16'hFFFF);
    step();
    chk("wrap_0000", pc, 16'h0000);

    // stall holds PC and blocks the branch
    stall = 1'b1; inst_valid = 1'b1; JMP = 1'b0; MP = 1'b1; offset = 8'h03;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 16'h0000);
      chk("stall_flush", flush, 0);
      chk("stall_cnt", taken_cnt, exp_taken);
    end
    MP = 1'bx; JMP = 1'bx;
    step();
    chk("stall_x_pc", pc, 16'h0000);
    chk("stall_x_state", fsm_state, 0);
    stall = 1'b0; inst_valid = 1'b1; JMP = 1'b0; MP = 1'b1; offset = 8'h03;
    do_taken("unstall", 16'h0004);
    chk("unstall_cnt", taken_cnt, 6);

    // saturation of the redirect counter
    for (int i = 0; i < 260; i++) begin
      inst_valid = 1'b1; JMP = 1'b1; MP = 1'b0; target = 16'(i * 3);
      do_taken("sat", 16'(i * 3));
    end
    chk("sat_final", taken_cnt, 255);

    // asynchronous reset in the middle of a flush window
    inst_valid = 1'b1; JMP = 1'b1; MP = 1'b0; target = 16'h0BEE;
    step();
    chk("pre_rst_flush", flush, 1);
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_valid", pc_valid, 1);
    chk("arst_flush", flush, 0);
    chk("arst_cnt", taken_cnt, 0);
    chk("arst_state", fsm_state, 0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_pc", pc, 16'h0001);
    chk("post_rst_valid", pc_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
